mac_job_scheduler: RTL and testbench
====================================

MAC_JOB_SCHEDULER -- requirements
Module: mac_job_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64, max cycles waited for each IRQ phase before an error completion.
REQ-002 SHALL have parameter IRQ_MSK, default 1, the value written to MAC_CTRL[0]; it must be 1 for normal completion.
REQ-003 clk  in  1  single clock; every flop is on its rising edge.
REQ-004 reset  in  1  reset is synchronous and active-low.
REQ-005 req[1:0]  in  2  per-requester job request, level, held until done.
REQ-006 ina0/ina1  in  32 each  per-requester MAC_INA operand.
REQ-007 inb0/inb1  in  32 each  per-requester MAC_INB operand.
REQ-008 mode0/mode1  in  2 each  per-requester input mode.
REQ-009 shift0/shift1  in  3 each  per-requester shifter select.
REQ-010 gnt[1:0]  out  2  one-hot owner of the MAC, held from grant until done.
REQ-011 done[1:0]  out  2  one-cycle completion pulse to the owner.
REQ-012 err  out  1  qualifies done: 1 = timeout or illegal mode.
REQ-013 acc_res  out  40  captured MAC_ACC, valid with done.
REQ-014 out_res  out  16  captured MAC_OUT, valid with done.
REQ-015 addr  out  8  register address to the MAC bus interface.
REQ-016 wdata  out  32  write data to the MAC bus interface.
REQ-017 we  out  1  write enable to the MAC bus interface.
REQ-018 rdata  in  32  bus read data, registered, valid one cycle after addr is presented with we=0.
REQ-019 irq  in  1  MAC interrupt, high while the last job is done.

Function
REQ-020 SHALL run the FSM IDLE -> GRANT -> W_INA -> W_INB -> W_CTRL -> WAIT_LO -> WAIT_HI -> W_STOP -> R_ACCL -> R_ACCH -> R_OUT -> R_CAP -> FIN -> IDLE.
REQ-021 Arbitration is evaluated only in IDLE, using round-robin: the requester not served last wins a tie; after reset requester 0 has priority.
REQ-022 In GRANT, gnt is set one-hot and the owner's fields are latched; later changes on those inputs are ignored until FIN.
REQ-023 If the latched mode is 2'b11, GRANT goes directly to FIN with err=1, no bus activity, and acc_res/out_res unchanged.
REQ-024 W_INA drives we=1, addr=0x24, wdata=ina.
REQ-025 W_INB drives we=1, addr=0x25, wdata=inb.
REQ-026 W_CTRL drives we=1, addr=0x29, wdata[7:0]={1, shift, mode, 1, IRQ_MSK}, all other wdata bits 0.
REQ-027 WAIT_LO waits for irq=0 (discards the stale done from the previous job); WAIT_HI then waits for irq=1; each state has its own counter, cleared on entry.
REQ-028 A counter reaching TIMEOUT_CYC sets the error flag and jumps to W_STOP.
REQ-029 W_STOP drives we=1, addr=0x29, wdata[7:0]={1, shift, mode, 0, IRQ_MSK}, which clears START so the next job produces a rising edge.
REQ-030 The read pipeline drives we=0 throughout:
- R_ACCL presents addr 0x26.
- R_ACCH presents addr 0x27 and captures acc_res[31:0] from rdata.
- R_OUT presents addr 0x28 and captures acc_res[39:32] from rdata[7:0].
- R_CAP captures out_res from rdata[15:0].
REQ-031 Reads occur on timeout as well, so acc_res/out_res always reflect the MAC state at the time of the read.
REQ-032 FIN pulses done[owner] for one cycle, drives err, clears gnt on the next edge, and records the owner as last-served.
REQ-033 Outside write states, we=0; outside bus states, addr=0x00 and wdata=0.
REQ-034 A req deasserted mid-job does not abort; the job completes and done is still pulsed.
REQ-035 A requester may re-request in the cycle after done; it then competes in the next IDLE.
REQ-036 Nominal latency from GRANT to done pulse, inclusive, is 10 + WAIT_LO cycles + WAIT_HI cycles.
REQ-037 err is held until the next GRANT; acc_res and out_res are held until the next capture.

Reset
REQ-038 When reset=0 at a clock edge, the FSM SHALL enter IDLE from any state, including mid-job, and all counters SHALL clear.
REQ-039 Reset values: gnt=0, done=0, err=0, acc_res=0, out_res=0, addr=0, wdata=0, we=0, last-served=1 (so requester 0 has priority).

Verification
REQ-040 Single job, no tie: req=01, ina0=0x0000_0003, inb0=0x0000_0005, mode0=01, shift0=000, bench MAC starts from ACC=0 -> acc_res=15, out_res=0, err=0, single done[0] pulse.
REQ-041 Bus order: same job as REQ-040 -> exact write sequence 0x24, 0x25, 0x29 (wdata[7:0]=0x87), 0x29 (wdata[7:0]=0x85), then reads 0x26, 0x27, 0x28 on consecutive cycles.
REQ-042 Round-robin: req=11 held -> grants alternate 0,1,0,1; no gnt overlap; each owner gets exactly one done per job.
REQ-043 Illegal mode: mode1=11, req=10 -> done[1] with err=1 two cycles after GRANT, we never asserted.
REQ-044 Timeout: irq stuck at 0 -> err=1, done pulsed TIMEOUT_CYC cycles after WAIT_HI entry plus the write/read tail.
REQ-045 Reset mid-job: reset=0 asserted during WAIT_HI -> next cycle all outputs at reset values; a fresh req=01 completes normally.

Source files
------------

// File: rtl/mac_job_scheduler_if.sv
// MAC register bus: scheduler (master) drives addr/wdata/we, MAC (slave) returns registered rdata and irq.
// No flow control on this bus; rdata is valid one cycle after a read address.
interface mac_job_scheduler_if;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        irq;

    modport master (output addr, wdata, we, input rdata, irq);
    modport slave  (input addr, wdata, we, output rdata, irq);
endinterface

// File: rtl/mac_job_scheduler.sv
// Round-robin two-requester job scheduler for a shared MAC; latency 10 + irq wait cycles (2 on illegal mode).
// Backpressure: requesters hold req until their done pulse; irq waits are bounded by TIMEOUT_CYC.
module mac_job_scheduler #(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter logic        IRQ_MSK     = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  req_i,
    input  logic [31:0] ina0_i,
    input  logic [31:0] ina1_i,
    input  logic [31:0] inb0_i,
    input  logic [31:0] inb1_i,
    input  logic [1:0]  mode0_i,
    input  logic [1:0]  mode1_i,
    input  logic [2:0]  shift0_i,
    input  logic [2:0]  shift1_i,
    output logic [1:0]  gnt_o,
    output logic [1:0]  done_o,
    output logic        err_o,
    output logic [39:0] acc_res_o,
    output logic [15:0] out_res_o,
    mac_job_scheduler_if.master bus
);
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_GRANT   = 4'd1;
    localparam logic [3:0] S_W_INA   = 4'd2;
    localparam logic [3:0] S_W_INB   = 4'd3;
    localparam logic [3:0] S_W_CTRL  = 4'd4;
    localparam logic [3:0] S_WAIT_LO = 4'd5;
    localparam logic [3:0] S_WAIT_HI = 4'd6;
    localparam logic [3:0] S_W_STOP  = 4'd7;
    localparam logic [3:0] S_R_ACCL  = 4'd8;
    localparam logic [3:0] S_R_ACCH  = 4'd9;
    localparam logic [3:0] S_R_OUT   = 4'd10;
    localparam logic [3:0] S_R_CAP   = 4'd11;
    localparam logic [3:0] S_FIN     = 4'd12;

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [3:0]    state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          err_q, err_d;
    logic [39:0]   acc_q, acc_d;
    logic [15:0]   out_q, out_d;
    logic [31:0]   ina_q, ina_d, inb_q, inb_d;
    logic [1:0]    mode_q, mode_d;
    logic [2:0]    shift_q, shift_d;
    logic [CW-1:0] cnt_lo_q, cnt_lo_d, cnt_hi_q, cnt_hi_d;
    logic [7:0]    bus_addr;
    logic [31:0]   bus_wdata;
    logic          bus_we;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        last_d    = last_q;
        err_d     = err_q;
        acc_d     = acc_q;
        out_d     = out_q;
        ina_d     = ina_q;
        inb_d     = inb_q;
        mode_d    = mode_q;
        shift_d   = shift_q;
        cnt_lo_d  = cnt_lo_q;
        cnt_hi_d  = cnt_hi_q;
        bus_addr  = 8'h00;
        bus_wdata = 32'h0;
        bus_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_i != 2'b00) begin
                    // a tie goes to whoever was not served last
                    owner_d = req_i[1] & (~req_i[0] | ~last_q);
                    gnt_d   = owner_d ? 2'b10 : 2'b01;
                    ina_d   = owner_d ? ina1_i   : ina0_i;
                    inb_d   = owner_d ? inb1_i   : inb0_i;
                    mode_d  = owner_d ? mode1_i  : mode0_i;
                    shift_d = owner_d ? shift1_i : shift0_i;
                    err_d   = 1'b0;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (mode_q == 2'b11) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    state_d = S_W_INA;
                end
            end
            S_W_INA: begin
                bus_we = 1'b1; bus_addr = 8'h24; bus_wdata = ina_q;
                state_d = S_W_INB;
            end
            S_W_INB: begin
                bus_we = 1'b1; bus_addr = 8'h25; bus_wdata = inb_q;
                state_d = S_W_CTRL;
            end
            S_W_CTRL: begin
                bus_we = 1'b1; bus_addr = 8'h29;
                bus_wdata = {24'h0, 1'b1, shift_q, mode_q, 1'b1, IRQ_MSK};
                cnt_lo_d = '0;
                state_d  = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                // irq is still high from the previous job until the MAC sees START rise
                if (!bus.irq) begin
                    cnt_hi_d = '0;
                    state_d  = S_WAIT_HI;
                end else if (cnt_lo_q == CW'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_W_STOP;
                end else begin
                    cnt_lo_d = cnt_lo_q + CW'(1);
                end
            end
            S_WAIT_HI: begin
                if (bus.irq) begin
                    state_d = S_W_STOP;
                end else if (cnt_hi_q == CW'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_W_STOP;
                end else begin
                    cnt_hi_d = cnt_hi_q + CW'(1);
                end
            end
            S_W_STOP: begin
                bus_we = 1'b1; bus_addr = 8'h29;
                bus_wdata = {24'h0, 1'b1, shift_q, mode_q, 1'b0, IRQ_MSK};
                state_d = S_R_ACCL;
            end
            S_R_ACCL: begin
                bus_addr = 8'h26;
                state_d  = S_R_ACCH;
            end
            S_R_ACCH: begin
                bus_addr = 8'h27;
                acc_d[31:0] = bus.rdata;
                state_d = S_R_OUT;
            end
            S_R_OUT: begin
                bus_addr = 8'h28;
                acc_d[39:32] = bus.rdata[7:0];
                state_d = S_R_CAP;
            end
            S_R_CAP: begin
                out_d   = bus.rdata[15:0];
                state_d = S_FIN;
            end
            S_FIN: begin
                last_d  = owner_q;
                gnt_d   = 2'b00;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            gnt_q    <= 2'b00;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            err_q    <= 1'b0;
            acc_q    <= '0;
            out_q    <= '0;
            ina_q    <= '0;
            inb_q    <= '0;
            mode_q   <= '0;
            shift_q  <= '0;
            cnt_lo_q <= '0;
            cnt_hi_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            err_q    <= err_d;
            acc_q    <= acc_d;
            out_q    <= out_d;
            ina_q    <= ina_d;
            inb_q    <= inb_d;
            mode_q   <= mode_d;
            shift_q  <= shift_d;
            cnt_lo_q <= cnt_lo_d;
            cnt_hi_q <= cnt_hi_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign done_o    = (state_q == S_FIN) ? gnt_q : 2'b00;
    assign err_o     = err_q;
    assign acc_res_o = acc_q;
    assign out_res_o = out_q;
    assign bus.addr  = bus_addr;
    assign bus.wdata = bus_wdata;
    assign bus.we    = bus_we;
endmodule

// File: tb/tb_mac_job_scheduler.sv
// Bench for mac_job_scheduler: behavioural MAC slave plus job-level reference (arbitration, bus order, latency, results).
module tb_mac_job_scheduler;
    localparam int T = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  req;
    logic [31:0] ina0, ina1, inb0, inb1;
    logic [1:0]  mode0, mode1;
    logic [2:0]  shift0, shift1;
    logic [1:0]  gnt, done;
    logic        err;
    logic [39:0] acc_res;
    logic [15:0] out_res;

    mac_job_scheduler_if mif ();

    mac_job_scheduler #(.TIMEOUT_CYC(T), .IRQ_MSK(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req),
        .ina0_i(ina0), .ina1_i(ina1), .inb0_i(inb0), .inb1_i(inb1),
        .mode0_i(mode0), .mode1_i(mode1), .shift0_i(shift0), .shift1_i(shift1),
        .gnt_o(gnt), .done_o(done), .err_o(err), .acc_res_o(acc_res), .out_res_o(out_res),
        .bus(mif)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // MAC behaviour: mode 0 loads a*b, mode 1 accumulates a*b, mode 2 adds 16a+b; OUT = ACC >> (16+shift)
    function automatic logic [39:0] mac_acc(input logic [39:0] acc, input logic [31:0] a,
                                            input logic [31:0] b, input logic [1:0] md);
        logic [39:0] p;
        p = {8'h0, a} * {8'h0, b};
        case (md)
            2'd0:    return p;
            2'd1:    return acc + p;
            default: return acc + ({8'h0, a} << 4) + {8'h0, b};
        endcase
    endfunction

    function automatic logic [15:0] mac_out(input logic [39:0] acc, input logic [2:0] sh);
        logic [39:0] t;
        t = acc >> (16 + int'(sh));
        return t[15:0];
    endfunction

    // ---------------- MAC slave model ----------------
    int fd = 0, lat_l = 1;
    bit stall = 1'b0;
    logic [31:0] m_ina = '0, m_inb = '0;
    logic [7:0]  m_ctrl;
    logic [39:0] m_acc = '0;
    logic [15:0] m_out = '0;
    int m_fall, m_rise;

    always @(posedge clk) begin
        if (!rst_n) begin
            mif.irq   <= 1'b1;
            mif.rdata <= '0;
            m_ctrl    <= '0;
            m_fall    <= -1;
            m_rise    <= -1;
        end else begin
            case (mif.addr)
                8'h26:   mif.rdata <= m_acc[31:0];
                8'h27:   mif.rdata <= {24'h0, m_acc[39:32]};
                8'h28:   mif.rdata <= {16'h0, m_out};
                default: mif.rdata <= '0;
            endcase
            if (m_fall == 0) mif.irq <= 1'b0;
            if (m_fall >= 0) m_fall <= m_fall - 1;
            if (m_rise == 0) begin
                mif.irq <= 1'b1;
                m_acc   <= mac_acc(m_acc, m_ina, m_inb, m_ctrl[3:2]);
                m_out   <= mac_out(mac_acc(m_acc, m_ina, m_inb, m_ctrl[3:2]), m_ctrl[6:4]);
            end
            if (m_rise >= 0) m_rise <= m_rise - 1;
            if (mif.we) begin
                case (mif.addr)
                    8'h24: m_ina <= mif.wdata;
                    8'h25: m_inb <= mif.wdata;
                    8'h29: begin
                        m_ctrl <= mif.wdata[7:0];
                        if (mif.wdata[1] && !m_ctrl[1]) begin
                            if (fd == 0) mif.irq <= 1'b0;
                            m_fall <= fd - 1;
                            m_rise <= stall ? -1 : fd + lat_l - 1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- bus / grant monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [39:0] wr_q[$];
    int          wr_cyc[$];
    logic [7:0]  rd_q[$];
    int          rd_cyc[$];
    int overlap_cnt = 0;
    int idle_bad    = 0;

    always @(negedge clk) begin
        if (gnt == 2'b11) overlap_cnt <= overlap_cnt + 1;
        if (mif.we) begin
            wr_q.push_back({mif.addr, mif.wdata});
            wr_cyc.push_back(cyc);
        end else if (mif.addr != 8'h00) begin
            rd_q.push_back(mif.addr);
            rd_cyc.push_back(cyc);
        end else if (mif.wdata != 32'h0) begin
            idle_bad <= idle_bad + 1;
        end
    end

    // ---------------- job-level reference state ----------------
    int          last_ref = 1;
    bit          irq_low  = 1'b0;
    logic [39:0] ref_acc  = '0;
    logic [15:0] ref_out  = '0;
    logic [39:0] cap_acc  = '0;
    logic [15:0] cap_out  = '0;

    task automatic run_job(input bit drop, input bit scramble, input bit do_stall, input bit release_all);
        int n, g, own, lat, exp_lat;
        logic [31:0] a, b;
        logic [1:0]  md;
        logic [2:0]  sh;
        logic [7:0]  cs;
        logic [39:0] exp_w[4];
        bit exp_err, illegal;
        stall = do_stall;
        fd    = irq_low ? 0 : int'($urandom_range(0, 3));
        lat_l = int'($urandom_range(1, T - 2));
        own   = (req == 2'b11) ? 1 - last_ref : (req[1] ? 1 : 0);
        n = 0;
        while (gnt == 2'b00 && n < 100) begin @(negedge clk); n++; end
        chk("grant_seen", {63'h0, gnt != 2'b00}, 64'h1);
        if (gnt == 2'b00) return;
        g = cyc;
        chk("grant_owner", {62'h0, gnt}, 64'h1 << own);
        a  = own ? ina1 : ina0;
        b  = own ? inb1 : inb0;
        md = own ? mode1 : mode0;
        sh = own ? shift1 : shift0;
        illegal = (md == 2'b11);
        wr_q.delete(); wr_cyc.delete(); rd_q.delete(); rd_cyc.delete();
        if (scramble) begin
            if (own == 1) begin
                ina1 = $urandom; inb1 = $urandom; mode1 = 2'($urandom_range(0, 2)); shift1 = 3'($urandom);
            end else begin
                ina0 = $urandom; inb0 = $urandom; mode0 = 2'($urandom_range(0, 2)); shift0 = 3'($urandom);
            end
        end
        if (drop) req[own] = 1'b0;
        n = 0;
        while (done == 2'b00 && n < 200) begin @(negedge clk); n++; end
        chk("done_seen", {63'h0, done != 2'b00}, 64'h1);
        if (done == 2'b00) return;
        if (release_all) req = 2'b00;
        lat = cyc - g + 1;
        chk("done_owner", {62'h0, done}, 64'h1 << own);
        if (illegal) begin
            exp_lat = 2;
            exp_err = 1'b1;
        end else begin
            exp_lat = 10 + (fd + 1) + (do_stall ? T : lat_l);
            exp_err = do_stall;
            if (!do_stall) begin
                ref_acc = mac_acc(ref_acc, a, b, md);
                ref_out = mac_out(ref_acc, sh);
            end
            irq_low = do_stall;
            cap_acc = ref_acc;
            cap_out = ref_out;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("err", {63'h0, err}, {63'h0, exp_err});
        chk("acc_res", {24'h0, acc_res}, {24'h0, cap_acc});
        chk("out_res", {48'h0, out_res}, {48'h0, cap_out});
        if (illegal) begin
            chk("illegal_no_writes", 64'(wr_q.size()), 64'd0);
            chk("illegal_no_reads", 64'(rd_q.size()), 64'd0);
        end else begin
            cs = {1'b1, sh, md, 1'b1, 1'b1};
            exp_w[0] = {8'h24, a};
            exp_w[1] = {8'h25, b};
            exp_w[2] = {8'h29, 24'h0, cs};
            cs[1] = 1'b0;
            exp_w[3] = {8'h29, 24'h0, cs};
            chk("write_count", 64'(wr_q.size()), 64'd4);
            for (int i = 0; i < 4; i++)
                if (i < wr_q.size()) chk($sformatf("write%0d", i), {24'h0, wr_q[i]}, {24'h0, exp_w[i]});
            if (wr_cyc.size() == 4) begin
                chk("w_ina_cycle", 64'(wr_cyc[0] - g), 64'd1);
                chk("w_ctrl_cycle", 64'(wr_cyc[2] - g), 64'd3);
                chk("w_stop_cycle", 64'(wr_cyc[3] - g), 64'(lat - 6));
            end
            chk("read_count", 64'(rd_q.size()), 64'd3);
            for (int i = 0; i < 3; i++)
                if (i < rd_q.size()) begin
                    chk($sformatf("read%0d_addr", i), {56'h0, rd_q[i]}, 64'h26 + 64'(i));
                    chk($sformatf("read%0d_cycle", i), 64'(rd_cyc[i] - g), 64'(lat - 5 + i));
                end
        end
        last_ref = own;
        @(negedge clk);
        chk("done_single_pulse", {62'h0, done}, 64'h0);
        chk("gnt_cleared", {62'h0, gnt}, 64'h0);
        chk("err_held", {63'h0, err}, {63'h0, exp_err});
        chk("acc_held", {24'h0, acc_res}, {24'h0, cap_acc});
    endtask

    task automatic rand_req(input int r);
        if (r == 1) begin
            ina1 = $urandom; inb1 = $urandom; mode1 = 2'($urandom_range(0, 2)); shift1 = 3'($urandom);
        end else begin
            ina0 = $urandom; inb0 = $urandom; mode0 = 2'($urandom_range(0, 2)); shift0 = 3'($urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int n, g;
        rst_n = 1'b0; req = 2'b00;
        ina0 = '0; ina1 = '0; inb0 = '0; inb1 = '0;
        mode0 = '0; mode1 = '0; shift0 = '0; shift1 = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {3'h0, gnt, done, err, acc_res, out_res}, 64'h0);
        chk("reset_bus", {23'h0, mif.we, mif.addr, mif.wdata}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // single job from ACC=0: 3*5 accumulated
        ina0 = 32'd3; inb0 = 32'd5; mode0 = 2'b01; shift0 = 3'b000; req = 2'b01;
        run_job(1'b0, 1'b0, 1'b0, 1'b1);
        chk("single_acc15", {24'h0, acc_res}, 64'd15);
        chk("single_out0", {48'h0, out_res}, 64'd0);

        // random single-requester jobs with mid-job input changes and req drops
        for (int k = 0; k < 6; k++) begin
            int r;
            r = int'($urandom_range(0, 1));
            rand_req(r);
            req = 2'b01 << r;
            run_job(1'($urandom), 1'($urandom), 1'b0, 1'b1);
        end

        // illegal mode on requester 1
        ina1 = $urandom; inb1 = $urandom; mode1 = 2'b11; shift1 = 3'($urandom);
        req = 2'b10;
        run_job(1'b0, 1'b0, 1'b0, 1'b1);

        // both requesting: owners must alternate
        rand_req(0); rand_req(1);
        req = 2'b11;
        for (int k = 0; k < 4; k++) run_job(1'b0, 1'b1, 1'b0, k == 3);
        chk("no_gnt_overlap", 64'(overlap_cnt), 64'd0);

        // irq never completes -> timeout
        rand_req(0);
        req = 2'b01;
        run_job(1'b0, 1'b0, 1'b1, 1'b1);

        // normal job right after a timeout (irq already low)
        rand_req(1);
        req = 2'b10;
        run_job(1'b0, 1'b0, 1'b0, 1'b1);

        // reset in WAIT_HI
        stall = 1'b1;
        fd    = irq_low ? 0 : int'($urandom_range(0, 3));
        rand_req(0);
        req = 2'b01;
        n = 0;
        while (gnt == 2'b00 && n < 100) begin @(negedge clk); n++; end
        chk("rst_job_grant", {62'h0, gnt}, 64'h1);
        g = cyc;
        n = 0;
        while (cyc < g + fd + 7 && n < 100) begin @(negedge clk); n++; end
        rst_n = 1'b0;
        req   = 2'b00;
        @(negedge clk);
        chk("midjob_reset_outputs", {3'h0, gnt, done, err, acc_res, out_res}, 64'h0);
        chk("midjob_reset_bus", {23'h0, mif.we, mif.addr, mif.wdata}, 64'h0);
        rst_n    = 1'b1;
        stall    = 1'b0;
        irq_low  = 1'b0;
        last_ref = 1;
        cap_acc  = '0;
        cap_out  = '0;
        @(negedge clk);
        // after reset requester 0 wins a tie
        rand_req(0); rand_req(1);
        req = 2'b11;
        run_job(1'b0, 1'b0, 1'b0, 1'b1);

        chk("final_no_overlap", 64'(overlap_cnt), 64'd0);
        chk("idle_bus_quiet", 64'(idle_bad), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
